// File: rtl/toll_pkg.sv
// Shared types and constants for the single-lane toll booth controller:
// FSM state encoding, vehicle type codes, per-class fees, display characters
// and the rate lookup payload.
package toll_pkg;

    localparam int unsigned BAL_W   = 16;
    localparam int unsigned FEE_W   = 8;
    localparam int unsigned TYPE_W  = 2;
    localparam int unsigned MSG_W   = 8;
    localparam int unsigned STATE_W = 3;
    localparam int unsigned COUNT_W = 16;
    localparam int unsigned REV_W   = 24;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK     = 3'd1,
        ST_DEDUCT    = 3'd2,
        ST_GATE_OPEN = 3'd3,
        ST_DENIED    = 3'd4
    } state_t;

    localparam logic [TYPE_W-1:0] VT_CAR     = 2'b00;
    localparam logic [TYPE_W-1:0] VT_TRUCK   = 2'b01;
    localparam logic [TYPE_W-1:0] VT_BIKE    = 2'b10;
    localparam logic [TYPE_W-1:0] VT_INVALID = 2'b11;

    localparam logic [FEE_W-1:0] FEE_CAR   = 8'd50;
    localparam logic [FEE_W-1:0] FEE_TRUCK = 8'd100;
    localparam logic [FEE_W-1:0] FEE_BIKE  = 8'd20;

    localparam logic [MSG_W-1:0] MSG_IDLE   = 8'h49; // 'I'
    localparam logic [MSG_W-1:0] MSG_CHECK  = 8'h43; // 'C'
    localparam logic [MSG_W-1:0] MSG_DEDUCT = 8'h50; // 'P'
    localparam logic [MSG_W-1:0] MSG_OPEN   = 8'h4F; // 'O'
    localparam logic [MSG_W-1:0] MSG_DENIED = 8'h58; // 'X'

    // Fee lookup result; valid=0 means the vehicle class is never admitted.
    typedef struct packed {
        logic [FEE_W-1:0] fee;
        logic             valid;
    } rate_t;

    // Display character shown while the FSM sits in a given state.
    function automatic logic [MSG_W-1:0] state_msg(input state_t s);
        case (s)
            ST_CHECK:     return MSG_CHECK;
            ST_DEDUCT:    return MSG_DEDUCT;
            ST_GATE_OPEN: return MSG_OPEN;
            ST_DENIED:    return MSG_DENIED;
            default:      return MSG_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/toll_rate_lut.sv
// Combinational vehicle class -> fee lookup.
// Ports:
//   vehicle_type  in   2  class code (car/truck/bike/invalid)
//   rate          out  {fee[7:0], valid}
module toll_rate_lut
    import toll_pkg::*;
(
    input  logic [TYPE_W-1:0] vehicle_type,
    output rate_t             rate
);

    always_comb begin
        rate = '0;
        case (vehicle_type)
            VT_CAR:   rate = '{fee: FEE_CAR,   valid: 1'b1};
            VT_TRUCK: rate = '{fee: FEE_TRUCK, valid: 1'b1};
            VT_BIKE:  rate = '{fee: FEE_BIKE,  valid: 1'b1};
            default:  rate = '0;
        endcase
    end

endmodule

// File: rtl/toll_system.sv
// Single-lane toll booth controller: latches a vehicle's class and card
// balance on detect, charges the class fee or denies passage, holds the
// barrier open for GATE_CYCLES cycles and drives an ASCII status character.
// Optional macro TOLL_STATS_EN adds saturating vehicle_count/revenue outputs.
// Ports:
//   clk               in   1   system clock, rising edge
//   reset             in   1   asynchronous active-high reset
//   vehicle_detected  in   1   vehicle present (sampled only in IDLE)
//   vehicle_type      in   2   vehicle class code
//   card_balance      in   16  card balance, unsigned
//   new_balance       out  16  balance after the last transaction
//   toll_deducted     out  8   fee charged by the last transaction
//   gate_open         out  1   barrier open
//   state             out  3   registered FSM state
//   display_msg       out  8   ASCII status character
//   vehicle_count     out  16  (TOLL_STATS_EN) admitted vehicles, saturating
//   revenue           out  24  (TOLL_STATS_EN) fees collected, saturating
module toll_system
    import toll_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 3,
    parameter int unsigned DENY_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vehicle_detected,
    input  logic [TYPE_W-1:0]  vehicle_type,
    input  logic [BAL_W-1:0]   card_balance,
    output logic [BAL_W-1:0]   new_balance,
    output logic [FEE_W-1:0]   toll_deducted,
    output logic               gate_open,
    output logic [STATE_W-1:0] state,
`ifdef TOLL_STATS_EN
    output logic [COUNT_W-1:0] vehicle_count,
    output logic [REV_W-1:0]   revenue,
`endif
    output logic [MSG_W-1:0]   display_msg
);

    localparam int unsigned MAX_CYC = (GATE_CYCLES > DENY_CYCLES) ? GATE_CYCLES : DENY_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DENY_LAST = CNT_W'(DENY_CYCLES - 1);

    state_t             state_q;
    logic [TYPE_W-1:0]  type_q;
    logic [BAL_W-1:0]   bal_q;
    logic [CNT_W-1:0]   cnt_q;
    rate_t              rate;
    logic               can_pay;

    // Fee for the latched vehicle, not the live input.
    toll_rate_lut u_rate_lut (
        .vehicle_type (type_q),
        .rate         (rate)
    );

    assign can_pay = rate.valid && (bal_q >= BAL_W'(rate.fee));
    assign state   = state_q;

    // Transaction FSM with registered outputs; display tracks the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            type_q        <= '0;
            bal_q         <= '0;
            cnt_q         <= '0;
            new_balance   <= '0;
            toll_deducted <= '0;
            gate_open     <= 1'b0;
            display_msg   <= MSG_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (vehicle_detected) begin
                        type_q      <= vehicle_type;
                        bal_q       <= card_balance;
                        state_q     <= ST_CHECK;
                        display_msg <= state_msg(ST_CHECK);
                    end
                end
                ST_CHECK: begin
                    cnt_q <= '0;
                    if (can_pay) begin
                        state_q     <= ST_DEDUCT;
                        display_msg <= state_msg(ST_DEDUCT);
                    end else begin
                        toll_deducted <= '0;
                        new_balance   <= bal_q;
                        state_q       <= ST_DENIED;
                        display_msg   <= state_msg(ST_DENIED);
                    end
                end
                ST_DEDUCT: begin
                    // can_pay guaranteed fee <= balance, so no underflow.
                    new_balance   <= bal_q - BAL_W'(rate.fee);
                    toll_deducted <= rate.fee;
                    gate_open     <= 1'b1;
                    cnt_q         <= '0;
                    state_q       <= ST_GATE_OPEN;
                    display_msg   <= state_msg(ST_GATE_OPEN);
                end
                ST_GATE_OPEN: begin
                    if (cnt_q == GATE_LAST) begin
                        gate_open   <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= ST_IDLE;
                        display_msg <= state_msg(ST_IDLE);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DENIED: begin
                    if (cnt_q == DENY_LAST) begin
                        cnt_q       <= '0;
                        state_q     <= ST_IDLE;
                        display_msg <= state_msg(ST_IDLE);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    gate_open   <= 1'b0;
                    cnt_q       <= '0;
                    state_q     <= ST_IDLE;
                    display_msg <= state_msg(ST_IDLE);
                end
            endcase
        end
    end

`ifdef TOLL_STATS_EN
    logic [REV_W:0] rev_sum;

    assign rev_sum = {1'b0, revenue} + (REV_W + 1)'(rate.fee);

    // Statistics update on DEDUCT -> GATE_OPEN, saturating at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vehicle_count <= '0;
            revenue       <= '0;
        end else if (state_q == ST_DEDUCT) begin
            if (vehicle_count != '1) begin
                vehicle_count <= vehicle_count + COUNT_W'(1);
            end
            revenue <= rev_sum[REV_W] ? '1 : rev_sum[REV_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_toll_system.sv
// Self-checking bench for toll_system: table-driven directed transactions,
// randomized transactions against a timeline model, and hand-written
// sequences for held detect, mid-gate async reset and ignored detects.
module tb_toll_system;

    logic        clk;
    logic        reset;
    logic        vehicle_detected;
    logic [1:0]  vehicle_type;
    logic [15:0] card_balance;
    logic [15:0] new_balance;
    logic [7:0]  toll_deducted;
    logic        gate_open;
    logic [2:0]  state;
    logic [7:0]  display_msg;
`ifdef TOLL_STATS_EN
    logic [15:0] vehicle_count;
    logic [23:0] revenue;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model of the programmer-visible outputs.
    logic [15:0] m_nb   = 16'd0;
    logic [7:0]  m_toll = 8'd0;
    int          m_count = 0;
    int          m_rev   = 0;

    typedef struct {
        logic [2:0]  st;
        logic [7:0]  msg;
        logic        gate;
        logic [15:0] nb;
        logic [7:0]  toll;
    } exp_t;

    typedef struct {
        logic [1:0]  vt;
        logic [15:0] bal;
        logic [7:0]  toll;
        logic [15:0] nb;
        bit          opens;
    } vec_t;

    toll_system dut (
        .clk              (clk),
        .reset            (reset),
        .vehicle_detected (vehicle_detected),
        .vehicle_type     (vehicle_type),
        .card_balance     (card_balance),
        .new_balance      (new_balance),
        .toll_deducted    (toll_deducted),
        .gate_open        (gate_open),
        .state            (state),
`ifdef TOLL_STATS_EN
        .vehicle_count    (vehicle_count),
        .revenue          (revenue),
`endif
        .display_msg      (display_msg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".state"}, 32'(state), 32'(e.st));
        chk({tag, ".msg"},   32'(display_msg), 32'(e.msg));
        chk({tag, ".gate"},  32'(gate_open), 32'(e.gate));
        chk({tag, ".nb"},    32'(new_balance), 32'(e.nb));
        chk({tag, ".toll"},  32'(toll_deducted), 32'(e.toll));
    endtask

    // Fee schedule straight from the tariff: car 50, truck 100, bike 20.
    function automatic int fee_of(input logic [1:0] vt);
        case (vt)
            2'd0:    return 50;
            2'd1:    return 100;
            2'd2:    return 20;
            default: return -1;
        endcase
    endfunction

    // One transaction with a one-cycle detect pulse; checks every cycle
    // until the lane is back in IDLE. noise re-asserts detect mid-flight.
    task automatic run_txn(input logic [1:0] vt, input logic [15:0] bal,
                           input bit noise, input string tag, output bit opened);
        exp_t tl[$];
        int   fee;
        bit   ok;
        fee    = fee_of(vt);
        ok     = (fee >= 0) && (int'(bal) >= fee);
        opened = 1'b0;
        tl.push_back('{3'd1, 8'h43, 1'b0, m_nb, m_toll});
        if (ok) begin
            tl.push_back('{3'd2, 8'h50, 1'b0, m_nb, m_toll});
            m_nb   = 16'(int'(bal) - fee);
            m_toll = 8'(fee);
            m_count++;
            m_rev += fee;
            for (int i = 0; i < 3; i++) tl.push_back('{3'd3, 8'h4F, 1'b1, m_nb, m_toll});
        end else begin
            m_nb   = bal;
            m_toll = 8'd0;
            for (int i = 0; i < 2; i++) tl.push_back('{3'd4, 8'h58, 1'b0, m_nb, m_toll});
        end
        tl.push_back('{3'd0, 8'h49, 1'b0, m_nb, m_toll});

        @(negedge clk);
        vehicle_type     = vt;
        card_balance     = bal;
        vehicle_detected = 1'b1;
        for (int k = 0; k < tl.size(); k++) begin
            @(negedge clk);
            // Scramble inputs after the latch to prove they are not re-sampled.
            vehicle_detected = noise && (k == 2);
            vehicle_type     = 2'($urandom_range(0, 3));
            card_balance     = 16'($urandom);
            if (gate_open) opened = 1'b1;
            chk_all($sformatf("%s.c%0d", tag, k), tl[k]);
        end
        vehicle_detected = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
        int n = 0;
        while (state !== st && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".reach"}, 32'(state), 32'(st));
    endtask

    vec_t vecs[10];
    bit   opened;

    initial begin
        vecs[0] = '{2'd0, 16'd200,   8'd50,  16'd150,   1'b1};
        vecs[1] = '{2'd1, 16'd150,   8'd100, 16'd50,    1'b1};
        vecs[2] = '{2'd2, 16'd10,    8'd0,   16'd10,    1'b0};
        vecs[3] = '{2'd2, 16'd20,    8'd20,  16'd0,     1'b1};
        vecs[4] = '{2'd3, 16'd500,   8'd0,   16'd500,   1'b0};
        vecs[5] = '{2'd1, 16'd99,    8'd0,   16'd99,    1'b0};
        vecs[6] = '{2'd0, 16'd50,    8'd50,  16'd0,     1'b1};
        vecs[7] = '{2'd0, 16'd49,    8'd0,   16'd49,    1'b0};
        vecs[8] = '{2'd1, 16'hFFFF,  8'd100, 16'hFF9B,  1'b1};
        vecs[9] = '{2'd3, 16'd0,     8'd0,   16'd0,     1'b0};

        reset            = 1'b1;
        vehicle_detected = 1'b0;
        vehicle_type     = 2'd0;
        card_balance     = 16'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_all("reset", '{3'd0, 8'h49, 1'b0, 16'd0, 8'd0});

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].vt, vecs[i].bal, 1'b0, $sformatf("vec%0d", i), opened);
            chk($sformatf("vec%0d.final_nb", i),   32'(new_balance),   32'(vecs[i].nb));
            chk($sformatf("vec%0d.final_toll", i), 32'(toll_deducted), 32'(vecs[i].toll));
            chk($sformatf("vec%0d.opened", i),     32'(opened),        32'(vecs[i].opens));
        end

        // Randomized transactions, biased toward the fee boundary.
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  vt;
            logic [15:0] bal;
            int          fee;
            vt  = 2'($urandom_range(0, 3));
            fee = fee_of(vt);
            case ($urandom_range(0, 3))
                0:       bal = 16'($urandom);
                1:       bal = (fee > 0) ? 16'(fee) : 16'($urandom);
                2:       bal = (fee > 0) ? 16'(fee - 1) : 16'($urandom);
                default: bal = 16'($urandom_range(0, 120));
            endcase
            run_txn(vt, bal, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i), opened);
        end

        // Detect held high re-triggers on return to IDLE.
        @(negedge clk);
        vehicle_type     = 2'd0;
        card_balance     = 16'd60;
        vehicle_detected = 1'b1;
        @(negedge clk);
        chk("hold.first_check", 32'(state), 32'd1);
        @(negedge clk);
        wait_state(3'd0, 20, "hold.idle");
        chk("hold.nb1", 32'(new_balance), 32'd10);
        chk("hold.gate_idle", 32'(gate_open), 32'd0);
        @(negedge clk);
        chk("hold.retrigger", 32'(state), 32'd1);
        vehicle_detected = 1'b0;
        wait_state(3'd0, 20, "hold.idle2");
        chk("hold.nb2", 32'(new_balance), 32'd10);
        chk("hold.toll2", 32'(toll_deducted), 32'd50);
        m_nb = 16'd10; m_toll = 8'd50; m_count += 2; m_rev += 100;

`ifdef TOLL_STATS_EN
        chk("stats.count", 32'(vehicle_count), 32'(m_count));
        chk("stats.rev",   32'(revenue),       32'(m_rev));
`endif

        // Async reset in the middle of GATE_OPEN.
        @(negedge clk);
        vehicle_type     = 2'd1;
        card_balance     = 16'd300;
        vehicle_detected = 1'b1;
        @(negedge clk);
        vehicle_detected = 1'b0;
        wait_state(3'd3, 10, "rst.gate");
        chk("rst.gate_high", 32'(gate_open), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk_all("rst.mid", '{3'd0, 8'h49, 1'b0, 16'd0, 8'd0});
`ifdef TOLL_STATS_EN
        chk("rst.count", 32'(vehicle_count), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        m_nb = 16'd0; m_toll = 8'd0; m_count = 0; m_rev = 0;
        @(negedge clk);
        chk_all("rst.after", '{3'd0, 8'h49, 1'b0, 16'd0, 8'd0});

        // Post-reset transaction behaves normally.
        run_txn(2'd2, 16'd21, 1'b1, "post", opened);
        chk("post.nb", 32'(new_balance), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
